// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Which requester owns the access in flight
  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data
// load/store. Data has priority; a bounded streak of data grants while a
// fetch is waiting forces the next grant to fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT     = 1,
  parameter int DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(DATA_STREAK + 1);

  state_t          r_state;
  owner_t          r_owner;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_streak;
  logic            r_if_ready;
  logic            r_d_ready;
  logic [31:0]     r_if_rdata;
  logic [31:0]     r_d_rdata;
  logic            r_mem_enable;
  logic            r_mem_wr;
  logic [31:0]     r_mem_addr;
  logic [31:0]     r_mem_data_in;

  logic            w_force_fetch;
  logic            w_grant_data;
  logic            w_grant_fetch;

  // Grant decision: data wins unless fetch has waited through a full streak
  always_comb begin
    w_force_fetch = if_req && (r_streak == SW'(DATA_STREAK));
    w_grant_data  = d_req && !w_force_fetch;
    w_grant_fetch = if_req && !w_grant_data;
  end

  // Access sequencer: grant, hold the memory for MEM_LAT cycles, pulse ready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_owner       <= OWN_FETCH;
      r_cnt         <= '0;
      r_streak      <= '0;
      r_if_ready    <= 1'b0;
      r_d_ready     <= 1'b0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
      r_mem_enable  <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
    end else begin
      // Ready outputs are single-cycle pulses
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_data) begin
            r_owner       <= OWN_DATA;
            r_mem_enable  <= 1'b1;
            r_mem_wr      <= d_wr;
            r_mem_addr    <= d_addr;
            r_mem_data_in <= d_wdata;
            r_cnt         <= CW'(MEM_LAT - 1);
            r_state       <= ST_ACCESS;
            // Only data grants that made a fetch wait extend the streak
            if (if_req) begin
              if (r_streak != SW'(DATA_STREAK))
                r_streak <= r_streak + SW'(1);
            end else begin
              r_streak <= '0;
            end
          end else if (w_grant_fetch) begin
            r_owner       <= OWN_FETCH;
            r_mem_enable  <= 1'b1;
            r_mem_wr      <= 1'b0;
            r_mem_addr    <= if_addr;
            r_mem_data_in <= '0;
            r_cnt         <= CW'(MEM_LAT - 1);
            r_state       <= ST_ACCESS;
            r_streak      <= '0;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == '0) begin
            if (r_owner == OWN_DATA) begin
              r_d_rdata <= mem_data_out;
              r_d_ready <= 1'b1;
            end else begin
              r_if_rdata <= mem_data_out;
              r_if_ready <= 1'b1;
            end
            // Drop enable and write together so a write never outlives enable
            r_mem_enable <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_rdata    = r_if_rdata;
  assign if_ready    = r_if_ready;
  assign d_rdata     = r_d_rdata;
  assign d_ready     = r_d_ready;
  assign mem_enable  = r_mem_enable;
  assign mem_wr      = r_mem_wr;
  assign mem_addr    = r_mem_addr;
  assign mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each attached to a small behavioural word memory.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic mem_init;

  int n_vec;
  int n_err;

  // Instance A signals (MEM_LAT=1, DATA_STREAK=4)
  logic        a_if_req, a_if_ready, a_d_req, a_d_wr, a_d_ready;
  logic        a_mem_enable, a_mem_wr;
  logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
  logic [31:0] a_mem_addr, a_mem_data_in, a_mem_data_out;

  // Instance B signals (MEM_LAT=3, DATA_STREAK=4)
  logic        b_if_req, b_if_ready, b_d_req, b_d_wr, b_d_ready;
  logic        b_mem_enable, b_mem_wr;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
  logic [31:0] b_mem_addr, b_mem_data_in, b_mem_data_out;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];

  mem_arbiter #(.MEM_LAT(1), .DATA_STREAK(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
    .d_req(a_d_req), .d_wr(a_d_wr), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_ready(a_d_ready),
    .mem_enable(a_mem_enable), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
    .mem_data_in(a_mem_data_in), .mem_data_out(a_mem_data_out)
  );

  mem_arbiter #(.MEM_LAT(3), .DATA_STREAK(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .d_req(b_d_req), .d_wr(b_d_wr), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready),
    .mem_enable(b_mem_enable), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
    .mem_data_in(b_mem_data_in), .mem_data_out(b_mem_data_out)
  );

  // Preloaded contents: word 4 (byte 0x10) holds an instruction, others tag their address
  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'h00A00093;
    return 32'hC0DE0000 | 32'(i * 4);
  endfunction

  assign a_mem_data_out = mem_a[a_mem_addr[9:2]];
  assign b_mem_data_out = mem_b[b_mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= init_word(i);
        mem_b[i] <= init_word(i);
      end
    end else begin
      if (a_mem_enable && a_mem_wr) mem_a[a_mem_addr[9:2]] <= a_mem_data_in;
      if (b_mem_enable && b_mem_wr) mem_b[b_mem_addr[9:2]] <= b_mem_data_in;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_init = 1'b1;
    tick();
    tick();
    mem_init = 1'b0;
    n_vec++; if (a_if_ready !== 1'b0) begin n_err++; $display("FAIL reset_if_ready got=%b want=0", a_if_ready); end
    n_vec++; if (a_d_ready !== 1'b0) begin n_err++; $display("FAIL reset_d_ready got=%b want=0", a_d_ready); end
    n_vec++; if (a_mem_enable !== 1'b0) begin n_err++; $display("FAIL reset_mem_enable got=%b want=0", a_mem_enable); end
    n_vec++; if (a_mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr got=%b want=0", a_mem_wr); end
    n_vec++; if (a_mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got=%h want=0", a_mem_addr); end
    n_vec++; if (a_if_rdata !== 32'h0 || a_d_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h/%h want=0/0", a_if_rdata, a_d_rdata); end
    rst = 1'b0;
    tick();
  endtask

  // Single fetch at MEM_LAT=1: ready on the second sample after request
  task automatic test_fetch();
    a_if_req = 1'b1; a_if_addr = 32'h10;
    tick();
    n_vec++; if (a_mem_enable !== 1'b1 || a_mem_wr !== 1'b0 || a_mem_addr !== 32'h10) begin
      n_err++; $display("FAIL fetch_access got en=%b wr=%b addr=%h want en=1 wr=0 addr=00000010", a_mem_enable, a_mem_wr, a_mem_addr); end
    n_vec++; if (a_if_ready !== 1'b0) begin n_err++; $display("FAIL fetch_early_ready got=%b want=0", a_if_ready); end
    tick();
    n_vec++; if (a_if_ready !== 1'b1 || a_if_rdata !== 32'h00A00093) begin
      n_err++; $display("FAIL fetch_data got ready=%b data=%h want ready=1 data=00a00093", a_if_ready, a_if_rdata); end
    n_vec++; if (a_mem_enable !== 1'b0) begin n_err++; $display("FAIL fetch_enable_drop got=%b want=0", a_mem_enable); end
    a_if_req = 1'b0;
    tick();
    n_vec++; if (a_if_ready !== 1'b0) begin n_err++; $display("FAIL fetch_pulse_width got=%b want=0", a_if_ready); end
  endtask

  // Store then load back the same word
  task automatic test_store();
    a_d_req = 1'b1; a_d_wr = 1'b1; a_d_addr = 32'h40; a_d_wdata = 32'hDEADBEEF;
    tick();
    n_vec++; if (a_mem_enable !== 1'b1 || a_mem_wr !== 1'b1 || a_mem_addr !== 32'h40 || a_mem_data_in !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL store_access got en=%b wr=%b addr=%h din=%h want 1 1 00000040 deadbeef", a_mem_enable, a_mem_wr, a_mem_addr, a_mem_data_in); end
    n_vec++; if (a_d_ready !== 1'b0) begin n_err++; $display("FAIL store_early_ready got=%b want=0", a_d_ready); end
    tick();
    n_vec++; if (a_d_ready !== 1'b1 || a_mem_enable !== 1'b0 || a_mem_wr !== 1'b0) begin
      n_err++; $display("FAIL store_done got ready=%b en=%b wr=%b want 1 0 0", a_d_ready, a_mem_enable, a_mem_wr); end
    a_d_req = 1'b0;
    tick();
    n_vec++; if (a_d_ready !== 1'b0) begin n_err++; $display("FAIL store_pulse_width got=%b want=0", a_d_ready); end
    a_d_req = 1'b1; a_d_wr = 1'b0;
    tick();
    tick();
    n_vec++; if (a_d_ready !== 1'b1 || a_d_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL store_readback got ready=%b data=%h want 1 deadbeef", a_d_ready, a_d_rdata); end
    a_d_req = 1'b0;
    tick();
  endtask

  // Fetch and load together: data at sample 2, fetch at sample 5
  task automatic test_simultaneous();
    int dc, ic, dn, in_;
    logic [31:0] dd, id;
    dc = 0; ic = 0; dn = 0; in_ = 0; dd = '0; id = '0;
    a_if_req = 1'b1; a_if_addr = 32'h10;
    a_d_req = 1'b1; a_d_wr = 1'b0; a_d_addr = 32'h44;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (a_d_ready) begin dn++; dc = c; dd = a_d_rdata; a_d_req = 1'b0; end
      if (a_if_ready) begin in_++; ic = c; id = a_if_rdata; a_if_req = 1'b0; end
    end
    a_d_req = 1'b0; a_if_req = 1'b0;
    n_vec++; if (dn !== 1 || in_ !== 1) begin n_err++; $display("FAIL simul_counts got d=%0d f=%0d want 1 1", dn, in_); end
    n_vec++; if (dc !== 2 || ic !== 5) begin n_err++; $display("FAIL simul_order got dcyc=%0d fcyc=%0d want 2 5", dc, ic); end
    n_vec++; if (dd !== 32'hC0DE0044 || id !== 32'h00A00093) begin
      n_err++; $display("FAIL simul_data got d=%h f=%h want c0de0044 00a00093", dd, id); end
  endtask

  // Data held continuously while fetch waits: D D D D F
  task automatic test_streak();
    logic [4:0] seq;
    int n, fcyc;
    logic [31:0] fd;
    seq = '0; n = 0; fcyc = 0; fd = '0;
    a_d_req = 1'b1; a_d_wr = 1'b0; a_d_addr = 32'h44;
    a_if_req = 1'b1; a_if_addr = 32'h10;
    for (int c = 1; c <= 40 && n < 5; c++) begin
      tick();
      if (a_d_ready) begin seq = {seq[3:0], 1'b1}; n++; end
      if (a_if_ready) begin seq = {seq[3:0], 1'b0}; n++; fcyc = c; fd = a_if_rdata; a_if_req = 1'b0; end
    end
    a_d_req = 1'b0; a_if_req = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (n !== 5 || seq !== 5'b11110) begin n_err++; $display("FAIL streak_seq got n=%0d seq=%b want 5 11110", n, seq); end
    n_vec++; if (fcyc !== 14 || fd !== 32'h00A00093) begin
      n_err++; $display("FAIL streak_fetch got cyc=%0d data=%h want 14 00a00093", fcyc, fd); end
  endtask

  // MEM_LAT=3 load: enable for 3 cycles with stable address, ready at sample 4
  task automatic test_lat3();
    int en_cnt, bad_addr, rc, rn;
    logic [31:0] rd;
    en_cnt = 0; bad_addr = 0; rc = 0; rn = 0; rd = '0;
    b_d_req = 1'b1; b_d_wr = 1'b0; b_d_addr = 32'h20;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (b_mem_enable) begin
        en_cnt++;
        if (b_mem_addr !== 32'h20 || b_mem_wr !== 1'b0) bad_addr++;
      end
      if (b_d_ready) begin rn++; rc = c; rd = b_d_rdata; b_d_req = 1'b0; end
    end
    b_d_req = 1'b0;
    n_vec++; if (en_cnt !== 3 || bad_addr !== 0) begin n_err++; $display("FAIL lat3_enable got cycles=%0d badaddr=%0d want 3 0", en_cnt, bad_addr); end
    n_vec++; if (rn !== 1 || rc !== 4) begin n_err++; $display("FAIL lat3_ready got count=%0d cyc=%0d want 1 4", rn, rc); end
    n_vec++; if (rd !== 32'hC0DE0020) begin n_err++; $display("FAIL lat3_data got=%h want c0de0020", rd); end
  endtask

  // Reset during an access, request held and serviced again afterwards
  task automatic test_reset_mid();
    int rc, rn;
    logic [31:0] rd;
    rc = 0; rn = 0; rd = '0;
    a_d_req = 1'b1; a_d_wr = 1'b0; a_d_addr = 32'h48;
    tick();
    n_vec++; if (a_mem_enable !== 1'b1) begin n_err++; $display("FAIL rstmid_in_access got en=%b want 1", a_mem_enable); end
    rst = 1'b1;
    tick();
    n_vec++; if (a_mem_enable !== 1'b0 || a_mem_wr !== 1'b0 || a_mem_addr !== 32'h0 || a_mem_data_in !== 32'h0) begin
      n_err++; $display("FAIL rstmid_mem got en=%b wr=%b addr=%h din=%h want all 0", a_mem_enable, a_mem_wr, a_mem_addr, a_mem_data_in); end
    n_vec++; if (a_d_ready !== 1'b0 || a_if_ready !== 1'b0 || a_d_rdata !== 32'h0 || a_if_rdata !== 32'h0) begin
      n_err++; $display("FAIL rstmid_resp got dr=%b fr=%b dd=%h fd=%h want all 0", a_d_ready, a_if_ready, a_d_rdata, a_if_rdata); end
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (a_d_ready) begin rn++; rc = c; rd = a_d_rdata; a_d_req = 1'b0; end
    end
    a_d_req = 1'b0;
    n_vec++; if (rn !== 1 || rc !== 2 || rd !== 32'hC0DE0048) begin
      n_err++; $display("FAIL rstmid_reservice got count=%0d cyc=%0d data=%h want 1 2 c0de0048", rn, rc, rd); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; mem_init = 1'b0;
    a_if_req = 1'b0; a_if_addr = '0; a_d_req = 1'b0; a_d_wr = 1'b0; a_d_addr = '0; a_d_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_wr = 1'b0; b_d_addr = '0; b_d_wdata = '0;
    test_reset();
    test_fetch();
    test_store();
    test_simultaneous();
    test_streak();
    test_lat3();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
